// File: rtl/char_buf_pkg.sv
// Shared types and constants for the character-buffer arbiter.
// No logic; constants, the clear-state enum and an address range helper.
// Optional buffer clear is enabled in the top by CHAR_BUF_ARB_CLEAR_EN.
package char_buf_pkg;

    localparam int         ADDR_W_DEFAULT = 12;
    localparam int         DEPTH_DEFAULT  = 2400;   // 80 columns x 30 rows
    localparam logic [7:0] BLANK_CHAR     = 8'h20;  // ASCII space

    typedef logic [ADDR_W_DEFAULT-1:0] char_addr_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

    // True when an address names a real character cell.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/char_buf_arb_rr_arb2.sv
// Two-way round-robin selector between the two buffer writers.
// Combinational grant; the last-grant pointer updates on the clock edge.
// The grant is only a selection; the pointer moves only when upd reports a completed transfer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // 1 means requester 1 won most recently; reset to 1 so requester 0 wins first.
    logic last_q;

    // Lone requester wins outright; on contention the one not granted last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner of the most recent completed transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (upd && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/char_buf_arb.sv
// Single-port character RAM arbiter: scanout > clear > round-robin writers (clear under CHAR_BUF_ARB_CLEAR_EN).
// Grants are combinational in the request cycle; scanout data returns one cycle after scan_req.
// Writers see rdy=0 while scanout or clear owns the RAM; out-of-range writes handshake but are dropped.
module char_buf_arb
    import char_buf_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // scanout read port
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_vld,
    output logic [DATA_W-1:0] scan_data,
    // writer 0
    input  logic              wr0_val,
    output logic              wr0_rdy,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    // writer 1
    input  logic              wr1_val,
    output logic              wr1_rdy,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    // buffer clear control
    input  logic              clr_start,
    output logic              clr_busy,
    // RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              clearing;     // clear sequence owns every non-scan slot
    logic [ADDR_W-1:0] clr_addr_w;   // next cell to blank
    logic              scan_vld_q;
    logic              wr_allow;
    logic [1:0]        wr_req;
    logic [1:0]        wr_gnt;
    logic              wr_done;
    logic              clr_go;

`ifdef CHAR_BUF_ARB_CLEAR_EN
    localparam char_addr_t CLR_LAST = char_addr_t'(DEPTH - 1);

    clr_state_t state_q, state_d;
    char_addr_t clr_cnt_q;

    // Clear state register; reset aborts a clear in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start on a pulse from IDLE; leave once the last cell has actually been written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_IDLE:  if (clr_start) state_d = CLR_CLEAR;
            CLR_CLEAR: if (!scan_req && (clr_cnt_q == CLR_LAST)) state_d = CLR_IDLE;
            default:   state_d = CLR_IDLE;
        endcase
    end

    // Clear address: restarts from 0 while idle, advances only on slots scanout left free.
    always_ff @(posedge clk) begin
        if (rst || (state_q == CLR_IDLE)) begin
            clr_cnt_q <= '0;
        end else if (!scan_req) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    assign clearing   = (state_q == CLR_CLEAR);
    assign clr_addr_w = ADDR_W'(clr_cnt_q);
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clearing         = 1'b0;
    assign clr_addr_w       = '0;
`endif

    // Writers compete only for slots that neither scanout nor clear claims.
    always_comb begin
        wr_allow = !rst && !scan_req && !clearing;
        wr_req   = {wr1_val, wr0_val} & {2{wr_allow}};
        clr_go   = !rst && !scan_req && clearing;
        wr_done  = (wr0_val && wr0_rdy) || (wr1_val && wr1_rdy);
    end

    rr_arb2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .upd (wr_done),
        .gnt (wr_gnt)
    );

    assign wr0_rdy = wr_gnt[0];
    assign wr1_rdy = wr_gnt[1];

    // RAM port mux: at most one owner per cycle, idle port when nobody is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst && scan_req) begin
            mem_en   = 1'b1;
            mem_addr = scan_addr;
        end else if (clr_go) begin
            if (addr_in_range(32'(clr_addr_w), DEPTH)) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr_w;
                mem_wdata = DATA_W'(BLANK_CHAR);
            end
        end else if (wr_gnt[0]) begin
            if (addr_in_range(32'(wr0_addr), DEPTH)) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr0_addr;
                mem_wdata = wr0_data;
            end
        end else if (wr_gnt[1]) begin
            if (addr_in_range(32'(wr1_addr), DEPTH)) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr1_addr;
                mem_wdata = wr1_data;
            end
        end
    end

    // Scanout response valid tracks the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_vld_q <= 1'b0;
        end else begin
            scan_vld_q <= scan_req;
        end
    end

    assign scan_vld  = scan_vld_q && !rst;
    assign scan_data = mem_rdata;
    assign clr_busy  = clearing && !rst;

endmodule

// File: tb/tb_char_buf_arb.sv
// Randomized scoreboard bench for char_buf_arb with an external RAM model.
// Per-cycle grant/RAM-port checks against a rule-level model; scan responses checked by a monitor.
// Clear scenarios are compiled in when CHAR_BUF_ARB_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_char_buf_arb;
    import char_buf_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2400;
    localparam int MEM_SZ = 4096;
`ifdef CHAR_BUF_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_req, scan_vld;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              wr0_val, wr0_rdy, wr1_val, wr1_rdy;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr;
    logic [DATA_W-1:0] wr0_data, wr1_data;
    logic              clr_start, clr_busy;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    char_buf_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_vld(scan_vld), .scan_data(scan_data),
        .wr0_val(wr0_val), .wr0_rdy(wr0_rdy), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_val(wr1_val), .wr1_rdy(wr1_rdy), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency; 2-state so it starts at zero.
    bit [7:0] ram [MEM_SZ];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: intended buffer contents, clear progress, last writer served.
    bit [7:0]   ref_mem [MEM_SZ];
    bit         clr_active = 1'b0;
    int         clr_idx    = 0;
    int         last_g     = 1;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scan response monitor: every response must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (scan_vld === 1'b1) begin
                if (exp_q.size() == 0) check("scan_vld_spurious", 32'(scan_vld), 32'd0);
                else                   check("scan_data", 32'(scan_data), 32'(exp_q.pop_front()));
            end else if (exp_q.size() != 0) begin
                check("scan_vld", 32'(scan_vld), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic int rand_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(DEPTH, MEM_SZ - 1));
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock cycle: drive inputs, predict who owns the RAM, compare, advance the model.
    task automatic cyc(input bit r, input bit s, input int sa,
                       input bit v0, input int a0, input int d0,
                       input bit v1, input int a1, input int d1, input bit cs);
        bit e_r0, e_r1, e_en, e_we;
        int e_addr, e_dat, g;
        @(negedge clk);
        rst = r; scan_req = s; scan_addr = ADDR_W'(sa);
        wr0_val = v0; wr0_addr = ADDR_W'(a0); wr0_data = DATA_W'(d0);
        wr1_val = v1; wr1_addr = ADDR_W'(a1); wr1_data = DATA_W'(d1);
        clr_start = cs;
        #1;
        e_r0 = 0; e_r1 = 0; e_en = 0; e_we = 0; e_addr = 0; e_dat = 0; g = -1;
        if (!r) begin
            if (s) begin
                e_en = 1; e_addr = sa;
                exp_q.push_back(ref_mem[sa]);
            end else if (clr_active) begin
                e_en = 1; e_we = 1; e_addr = clr_idx; e_dat = 32'h20;
                ref_mem[clr_idx] = 8'h20;
            end else begin
                if (v0 && v1) g = (last_g == 0) ? 1 : 0;
                else if (v0)  g = 0;
                else if (v1)  g = 1;
                if (g >= 0) begin
                    e_r0 = (g == 0); e_r1 = (g == 1); last_g = g;
                    e_addr = (g == 1) ? a1 : a0;
                    e_dat  = ((g == 1) ? d1 : d0) & 255;
                    if (e_addr < DEPTH) begin
                        e_en = 1; e_we = 1;
                        ref_mem[e_addr] = 8'(e_dat);
                    end
                end
            end
        end
        check("wr0_rdy", 32'(wr0_rdy), 32'(e_r0));
        check("wr1_rdy", 32'(wr1_rdy), 32'(e_r1));
        check("clr_busy", 32'(clr_busy), 32'(!r && clr_active));
        check("mem_en", 32'(mem_en), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_we));
        if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_dat));
        if (r) begin
            clr_active = 0; last_g = 1;
        end else if (clr_active) begin
            if (!s) begin
                if (clr_idx == DEPTH - 1) clr_active = 0;
                else                      clr_idx++;
            end
        end else if (cs && CLEAR_EN) begin
            clr_active = 1; clr_idx = 0;
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int port, input int a, input int d);
        if (port == 0) cyc(0, 0, 0, 1, a, d, 0, 0, 0, 0);
        else           cyc(0, 0, 0, 0, 0, 0, 1, a, d, 0);
    endtask

    task automatic scan(input int a);
        cyc(0, 1, a, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit s;
        int n;
        rst = 1; scan_req = 0; scan_addr = '0; clr_start = 0;
        wr0_val = 0; wr0_addr = '0; wr0_data = '0;
        wr1_val = 0; wr1_addr = '0; wr1_data = '0;

        // reset: all grants and RAM strobes low
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 1, 1, 1, 1, 2, 2, 1);

        // both writers contending: wr0, wr1, wr0, wr1
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 20 + i, 'h10 + i, 1, 30 + i, 'h20 + i, 0);

        // scan beats a pending writer, response one cycle later
        wr(0, 5, 'h5a);
        cyc(0, 1, 5, 1, 6, 'h66, 0, 0, 0, 0);
        idle();

        // write through wr1 then read it back
        wr(1, 10, 'h41);
        scan(10);
        idle();

        // out-of-range writes handshake but leave the RAM alone
        wr(0, 2400, 'h55);
        wr(1, 4095, 'h77);
        scan(2400);
        scan(4095);
        idle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            s = ($urandom_range(0, 3) == 0);
            cyc(0, s, int'($urandom_range(0, MEM_SZ - 1)),
                1'($urandom_range(0, 1)), rand_addr(), int'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), rand_addr(), int'($urandom_range(0, 255)), 0);
        end
        idle();

`ifdef CHAR_BUF_ARB_CLEAR_EN
        // full clear with scan every other cycle and writers always pending
        for (int i = 0; i < 5; i++) wr(0, 100 + i, 'ha0 + i);
        wr(1, 2399, 'hc3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n = 0;
        while (clr_active && n < 6000) begin
            cyc(0, (n % 2) == 0, rand_addr(),
                1, rand_addr(), int'($urandom_range(0, 255)),
                1, rand_addr(), int'($urandom_range(0, 255)), (n % 7) == 3);
            n++;
        end
        check("clear_finished", 32'(clr_active), 32'd0);
        idle();
        for (int i = 0; i < DEPTH; i++) scan(i);
        idle();

        // reset in the middle of a clear leaves the upper cells untouched
        for (int i = 0; i < 5; i++) wr(1, 100 + i, 'hb0 + i);
        wr(0, 2399, 'hd4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n = 0;
        while (!(clr_active && clr_idx == 100) && n < 300) begin
            idle();
            n++;
        end
        check("clear_reached_100", 32'(clr_idx), 32'd100);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        for (int i = 95; i < 111; i++) scan(i);
        scan(2399);
        idle();
`else
        // clear disabled: clr_start is ignored and writers keep flowing
        cyc(0, 0, 0, 1, 50, 'h31, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 51, 'h32, 0);
        cyc(0, 0, 0, 1, 52, 'h33, 1, 53, 'h34, 0);
        scan(50);
        scan(51);
        scan(52);
        idle();
`endif

        idle();
        check("scan_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_buf_arb.md
CHAR_BUF_ARB -- requirements
Module: char_buf_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning character-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning character code width.
REQ-003 SHALL have parameter DEPTH, default 2400, meaning the number of valid buffer entries (80x30).
REQ-004 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports scan_req  in  1 and scan_addr  in  ADDR_W, meaning the VGA scanout read request.
REQ-007 SHALL have ports scan_vld  out  1 and scan_data  out  DATA_W, meaning the scanout read response.
REQ-008 SHALL have ports wrN_val  in  1, wrN_rdy  out  1, wrN_addr  in  ADDR_W and wrN_data  in  DATA_W, for N = 0 and N = 1, meaning the write requesters.
REQ-009 SHALL have ports clr_start  in  1 and clr_busy  out  1, meaning the buffer-clear control.
REQ-010 SHALL have ports mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W and mem_rdata  in  DATA_W, meaning a single-port RAM with 1-cycle read latency.

Function
REQ-011 SHALL grant exactly one of {scan, clear, wr0, wr1}, or none, per cycle.
REQ-012 SHALL give scan absolute priority: scan_req=1 drives mem_en=1, mem_we=0 and mem_addr=scan_addr in the same cycle, and forces wr0_rdy=wr1_rdy=0.
REQ-013 SHALL assert scan_vld exactly 1 cycle after each scan_req and drive scan_data=mem_rdata while scan_vld=1.
REQ-014 SHALL drive wrN_rdy combinationally as "granted this cycle"; rdy may depend on val, and a transfer occurs only when val&&rdy, driving mem_en=1, mem_we=1 and the requester's addr/data.
REQ-015 SHALL arbitrate wr0 against wr1 round-robin: when both are valid, grant the one not granted most recently; the last-grant pointer updates only on a completed write transfer.
REQ-016 SHALL grant a lone valid writer immediately when scan_req=0 and no clear is in progress.
REQ-017 SHALL drop (neither issue nor wrap) any write or clear transfer with addr >= DEPTH, while still completing the handshake.
REQ-018 SHALL drive mem_en=0 and mem_we=0 in cycles with no grant.

Reset
REQ-019 SHALL, while rst=1, hold scan_vld=0, wr0_rdy=0, wr1_rdy=0, mem_en=0, mem_we=0 and clr_busy=0.
REQ-020 SHALL, on reset, set the round-robin pointer so that wr0 wins the first contested cycle.
REQ-021 SHALL, on rst mid-clear, abort the clear immediately without completing it, and return to IDLE.

Configuration
REQ-022 SHALL, with CHAR_BUF_ARB_CLEAR_EN defined, implement clear FSM IDLE->CLEAR on a clr_start pulse when in IDLE; clr_start SHALL be ignored while in CLEAR.
REQ-023 SHALL, in CLEAR, write BLANK_CHAR to addresses 0..DEPTH-1 in ascending order, one per non-scan cycle; scan_req stalls the address counter.
REQ-024 SHALL, in CLEAR, assert clr_busy and hold wr0_rdy=wr1_rdy=0.
REQ-025 SHALL return CLEAR->IDLE after the write to address DEPTH-1, deasserting clr_busy on the following cycle.
REQ-026 SHALL, without CHAR_BUF_ARB_CLEAR_EN, keep the ports present, ignore clr_start and tie clr_busy to 0.

Structure
REQ-027 SHALL take DEPTH_DEFAULT, BLANK_CHAR (8'h20), the char_addr_t typedef and the clear-state enum from package char_buf_pkg.
REQ-028 SHALL implement two-way round-robin selection in sub-module rr_arb2 (inputs req[1:0] and upd; output gnt[1:0]).

Verification
REQ-029 SHALL cover: scan_req=1, scan_addr=5 with wr0_val=1 -> wr0_rdy=0, mem_addr=5, and scan_vld=1 with scan_data=mem[5] on the next cycle.
REQ-030 SHALL cover: wr0 and wr1 both continuously valid, no scan, for 4 cycles -> grants wr0, wr1, wr0, wr1.
REQ-031 SHALL cover: wr1 writes addr 10 = 8'h41, then scan reads addr 10 -> scan_data=8'h41.
REQ-032 SHALL cover: clr_start with scan_req toggling every other cycle -> clr_busy high until all 2400 entries read back 8'h20, and writers are never granted during the clear.
REQ-033 SHALL cover: wr0 to addr 2400 -> handshake completes, mem_we=0, and no memory change.
REQ-034 SHALL cover: rst asserted at clear address 100 -> clr_busy=0 next cycle, and entries 100 and above keep their old data.
